rah_div_host_if: RTL and testbench

RAH_DIV_HOST_IF -- requirements
Module: rah_div_host_if

---
 rtl/rah_div_host_if.sv | 207 ++++++++++++++++++++
 tb/tb_rah_div_host_if.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rah_div_host_if.sv
// ---------------------------------------------------------------------------
// rah_div_host_if
//
// Host-side adapter between a 96-bit divide request/result handshake and a
// pair of 48-bit FIFOs that feed and drain a divider engine.
//
// TX path: an accepted request is captured into a hold register and written
// to the request FIFO as two words, low half first, then high half. The
// request counts as in flight once its high half has been written.
//
// RX path: two result words are read from the result FIFO, high half first,
// and assembled into a 96-bit result that is held until the consumer takes
// it. The FIFO returns data one cycle after the read strobe, so a read is
// marked pending for one cycle and the word is captured on the edge that
// follows.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_data/req_ready   96-bit request handshake
//   tx_full/tx_wr_en/tx_wr_data    request FIFO write side (48-bit words)
//   rx_empty/rx_rd_en/rx_data      result FIFO read side (48-bit words)
//   res_valid/res_data/res_ready   96-bit result handshake
//   outstanding                    requests in flight without a result
//   err_unexpected                 sticky: result arrived with none in flight
// ---------------------------------------------------------------------------
module rah_div_host_if #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [95:0] req_data,
    output logic        req_ready,
    input  logic        tx_full,
    output logic        tx_wr_en,
    output logic [47:0] tx_wr_data,
    input  logic        rx_empty,
    output logic        rx_rd_en,
    input  logic [47:0] rx_data,
    output logic        res_valid,
    output logic [95:0] res_data,
    input  logic        res_ready,
    output logic [3:0]  outstanding,
    output logic        err_unexpected
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LO   = 2'd1,
        TX_HI   = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_W0  = 2'd0,
        RX_W1  = 2'd1,
        RX_OUT = 2'd2
    } rx_state_t;

    tx_state_t   tx_state, tx_next;
    rx_state_t   rx_state, rx_next;
    logic [95:0] hold;
    logic        hold_load;
    logic        tx_done;      // high half written this cycle
    logic        rd_pending;
    logic        cap_hi;
    logic        cap_lo;
    logic        res_taken;    // result handed to the consumer this cycle

    // -----------------------------------------------------------------------
    // TX FSM
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a signal unassigned and no latch forms.
    always_comb begin
        tx_next    = tx_state;
        hold_load  = 1'b0;
        tx_done    = 1'b0;
        req_ready  = 1'b0;
        tx_wr_en   = 1'b0;
        tx_wr_data = hold[47:0];
        case (tx_state)
            TX_IDLE: begin
                req_ready = (outstanding < MAX_OUT);
                if (req_valid && req_ready) begin
                    hold_load = 1'b1;
                    tx_next   = TX_LO;
                end
            end
            TX_LO: begin
                tx_wr_en = !tx_full;
                if (tx_wr_en) begin
                    tx_next = TX_HI;
                end
            end
            TX_HI: begin
                tx_wr_en   = !tx_full;
                tx_wr_data = hold[95:48];
                if (tx_wr_en) begin
                    tx_done = 1'b1;
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // NOTE: the payload registers are wide but are still cleared on reset so
    // nothing from an abandoned transfer is visible once reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (hold_load) begin
            hold <= req_data;
        end
    end

    // -----------------------------------------------------------------------
    // RX FSM
    // -----------------------------------------------------------------------
    always_comb begin
        rx_next   = rx_state;
        rx_rd_en  = 1'b0;
        res_valid = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        res_taken = 1'b0;
        case (rx_state)
            RX_W0: begin
                rx_rd_en = !rd_pending && !rx_empty;
                if (rd_pending) begin
                    cap_hi  = 1'b1;
                    rx_next = RX_W1;
                end
            end
            RX_W1: begin
                rx_rd_en = !rd_pending && !rx_empty;
                if (rd_pending) begin
                    cap_lo  = 1'b1;
                    rx_next = RX_OUT;
                end
            end
            RX_OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_taken = 1'b1;
                    rx_next   = RX_W0;
                end
            end
            default: rx_next = RX_W0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_W0;
            rd_pending <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            // A read strobe is never issued while a read is pending, so the
            // flag is simply the strobe delayed by one cycle.
            rd_pending <= rx_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
        end else begin
            if (cap_hi) res_data[95:48] <= rx_data;
            if (cap_lo) res_data[47:0]  <= rx_data;
        end
    end

    // -----------------------------------------------------------------------
    // In-flight accounting
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding    <= '0;
            err_unexpected <= 1'b0;
        end else begin
            // The first word of a result with nothing in flight is flagged;
            // the result is still delivered and its decrement saturates.
            if (cap_hi && (outstanding == 4'd0)) begin
                err_unexpected <= 1'b1;
            end
            case ({tx_done, res_taken})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_rah_div_host_if.sv
// ---------------------------------------------------------------------------
// tb_rah_div_host_if
//
// Self-checking bench for rah_div_host_if. The bench plays the request FIFO,
// the result FIFO and a divider: every request written out is divided
// (dividend = upper half, divisor = lower half) and the quotient/remainder
// pair is queued as the result. A driver issues stimulus and pushes the
// expected FIFO words; a separate monitor pops and compares whatever the DUT
// presents and tracks the in-flight count.
// ---------------------------------------------------------------------------
module tb_rah_div_host_if;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [95:0] req_data = '0;
    logic        req_ready;
    logic        tx_full = 1'b0;
    logic        tx_wr_en;
    logic [47:0] tx_wr_data;
    logic        rx_empty = 1'b1;
    logic        rx_rd_en;
    logic [47:0] rx_data = '0;
    logic        res_valid;
    logic [95:0] res_data;
    logic        res_ready = 1'b0;
    logic [3:0]  outstanding;
    logic        err_unexpected;

    rah_div_host_if #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .tx_full        (tx_full),
        .tx_wr_en       (tx_wr_en),
        .tx_wr_data     (tx_wr_data),
        .rx_empty       (rx_empty),
        .rx_rd_en       (rx_rd_en),
        .rx_data        (rx_data),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [47:0] tx_exp[$];     // words the request FIFO should receive
    logic [95:0] res_exp[$];    // results the consumer should receive
    logic [47:0] rx_fifo[$];    // contents of the modelled result FIFO
    int          errors = 0;
    int          checks = 0;
    int          out_model = 0;
    bit          hi_next = 1'b0;
    logic [47:0] last_lo = '0;
    bit          rd_fired = 1'b0;
    bit          acc = 1'b0;
    bit          auto_div = 1'b0;

    // Driver knobs
    bit          manual = 1'b1;
    logic        m_req_valid = 1'b0;
    logic [95:0] m_req_data = '0;
    logic        m_tx_full = 1'b0;
    logic        m_res_ready = 1'b0;
    int          p_req = 0;
    int          p_full = 0;
    int          p_ready = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic logic [95:0] rand_req();
        logic [47:0] a;
        logic [47:0] d;
        a = 48'({$urandom(), $urandom()});
        case ($urandom_range(2))
            0:       d = 48'($urandom_range(255));
            1:       d = 48'($urandom());
            default: d = 48'({$urandom(), $urandom()});
        endcase
        if (d == '0) d = 48'd1;
        return {a, d};
    endfunction

    // One clock cycle: inputs change on the falling edge, handshakes are
    // sampled 1 ns later and take effect at the following rising edge.
    task automatic step();
        @(negedge clk);
        if (rd_fired) begin
            if (rx_fifo.size() > 0) rx_data = rx_fifo.pop_front();
            rd_fired = 1'b0;
        end
        rx_empty = (rx_fifo.size() == 0);
        if (manual) begin
            req_valid = m_req_valid;
            req_data  = m_req_data;
            tx_full   = m_tx_full;
            res_ready = m_res_ready;
        end else begin
            if (!(req_valid && !acc)) begin
                req_valid = ($urandom_range(99) < p_req);
                req_data  = rand_req();
            end
            tx_full   = ($urandom_range(99) < p_full);
            res_ready = ($urandom_range(99) < p_ready);
        end
        #1;
        acc = req_valid && req_ready;
        if (acc) begin
            tx_exp.push_back(req_data[47:0]);
            tx_exp.push_back(req_data[95:48]);
        end
        if (rx_rd_en) rd_fired = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        m_req_valid = 1'b0;
        acc         = 1'b0;
        rd_fired    = 1'b0;
        rx_empty    = 1'b1;
        tx_exp.delete();
        res_exp.delete();
        rx_fifo.delete();
        out_model   = 0;
        hi_next     = 1'b0;
        #1;
        check("rst_req_ready",   96'(req_ready),      96'd1);
        check("rst_tx_wr_en",    96'(tx_wr_en),       96'd0);
        check("rst_tx_wr_data",  96'(tx_wr_data),     96'd0);
        check("rst_rx_rd_en",    96'(rx_rd_en),       96'd0);
        check("rst_res_valid",   96'(res_valid),      96'd0);
        check("rst_res_data",    res_data,            96'd0);
        check("rst_outstanding", 96'(outstanding),    96'd0);
        check("rst_err",         96'(err_unexpected), 96'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_req(input logic [95:0] d);
        int n = 0;
        m_req_valid = 1'b1;
        m_req_data  = d;
        do begin
            step();
            n++;
        end while (!acc && n < 30);
        m_req_valid = 1'b0;
        if (!acc) fail_timeout("req_accept");
    endtask

    task automatic wait_res_hs(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(res_valid && res_ready) && n < 60);
        if (!(res_valid && res_ready)) fail_timeout(name);
    endtask

    task automatic push_result(input logic [95:0] r);
        rx_fifo.push_back(r[95:48]);
        rx_fifo.push_back(r[47:0]);
        res_exp.push_back(r);
    endtask

    // -----------------------------------------------------------------------
    // Monitor: compares every FIFO write and every presented result against
    // the queues, and checks the in-flight count every cycle.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        logic [47:0] w;
        logic [47:0] q;
        logic [47:0] r;
        bit          inc;
        bit          dec;
        #2;
        if (rst_n) begin
            check("outstanding", 96'(outstanding), 96'(out_model));
            inc = 1'b0;
            dec = 1'b0;
            if (tx_wr_en) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra_write: got %h, expected no write (t=%0t)", tx_wr_data, $time);
                end else begin
                    w = tx_exp.pop_front();
                    check("tx_wr_data", 96'(tx_wr_data), 96'(w));
                    if (hi_next) begin
                        inc = 1'b1;
                        if (auto_div) begin
                            q = w / last_lo;
                            r = w % last_lo;
                            push_result({q, r});
                        end
                    end else begin
                        last_lo = w;
                    end
                    hi_next = !hi_next;
                end
            end
            if (res_valid) begin
                if (res_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got %h, expected no result (t=%0t)", res_data, $time);
                end else begin
                    check("res_data", res_data, res_exp[0]);
                    if (res_ready) begin
                        void'(res_exp.pop_front());
                        dec = 1'b1;
                    end
                end
            end
            if (inc && !dec) out_model++;
            else if (dec && !inc && out_model > 0) out_model--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] x;
        int n;

        do_reset();

        // Single request: low half then high half on consecutive cycles.
        x = 96'h000000000001_000000000002;
        send_req(x);
        step();
        check("single_lo_en",   96'(tx_wr_en),   96'd1);
        check("single_lo_data", 96'(tx_wr_data), 96'h2);
        step();
        check("single_hi_en",   96'(tx_wr_en),   96'd1);
        check("single_hi_data", 96'(tx_wr_data), 96'h1);
        step();
        check("single_out",     96'(outstanding), 96'd1);
        check("single_idle_en", 96'(tx_wr_en),    96'd0);

        // Backpressure while the upper half is due.
        x = 96'h123456789ABC_0FEDCBA98765;
        send_req(x);
        step();
        check("bp_lo_data", 96'(tx_wr_data), 96'h0FEDCBA98765);
        m_tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_full_en",   96'(tx_wr_en),   96'd0);
            check("bp_full_data", 96'(tx_wr_data), 96'h123456789ABC);
        end
        m_tx_full = 1'b0;
        step();
        check("bp_hi_en",   96'(tx_wr_en),   96'd1);
        check("bp_hi_data", 96'(tx_wr_data), 96'h123456789ABC);
        step();
        check("bp_no_extra", 96'(tx_wr_en),   96'd0);
        check("bp_out",      96'(outstanding), 96'd2);

        // Result assembly and holding under res_ready = 0.
        m_res_ready = 1'b0;
        push_result(96'hAAAAAAAAAAAA_555555555555);
        n = 0;
        do begin
            step();
            n++;
        end while (!res_valid && n < 30);
        if (!res_valid) fail_timeout("res_appear");
        for (int i = 0; i < 3; i++) begin
            check("res_hold_valid", 96'(res_valid), 96'd1);
            check("res_hold_data",  res_data,       96'hAAAAAAAAAAAA_555555555555);
            if (i < 2) step();
        end
        check("res_hold_out", 96'(outstanding), 96'd2);
        m_res_ready = 1'b1;
        step();
        check("res_take_hs", 96'(res_valid && res_ready), 96'd1);
        m_res_ready = 1'b0;
        step();
        check("res_take_out",   96'(outstanding), 96'd1);
        check("res_take_valid", 96'(res_valid),   96'd0);

        // Outstanding limit.
        for (int i = 0; i < 3; i++) send_req(rand_req());
        repeat (3) step();
        check("limit_out", 96'(outstanding), 96'(MAXO));
        for (int i = 0; i < 3; i++) begin
            step();
            check("limit_ready", 96'(req_ready), 96'd0);
        end
        push_result(96'h000000000007_000000000003);
        m_res_ready = 1'b1;
        wait_res_hs("limit_hs");
        step();
        check("limit_freed_ready", 96'(req_ready),   96'd1);
        check("limit_freed_out",   96'(outstanding), 96'(MAXO - 1));

        // Drain the rest so nothing is in flight.
        for (int i = 0; i < MAXO - 1; i++) push_result(rand_req());
        n = 0;
        while ((res_exp.size() != 0 || rx_fifo.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (res_exp.size() != 0) fail_timeout("drain");
        repeat (2) step();
        check("drain_out", 96'(outstanding),    96'd0);
        check("drain_err", 96'(err_unexpected), 96'd0);

        // Result with nothing in flight.
        push_result(96'hDEADBEEF0000_00000000CAFE);
        wait_res_hs("unexp_hs");
        step();
        check("unexp_err", 96'(err_unexpected), 96'd1);
        check("unexp_out", 96'(outstanding),    96'd0);
        repeat (2) step();
        check("unexp_err_sticky", 96'(err_unexpected), 96'd1);

        // Reset after the first word of a result has been captured.
        do_reset();
        m_res_ready = 1'b0;
        rx_fifo.push_back(48'h111111111111);
        rx_fifo.push_back(48'h222222222222);
        n = 0;
        do begin
            step();
            n++;
        end while (rx_fifo.size() != 1 && n < 30);
        if (rx_fifo.size() != 1) fail_timeout("mid_first_word");
        do_reset();
        step();
        check("mid_valid", 96'(res_valid),   96'd0);
        check("mid_out",   96'(outstanding), 96'd0);
        push_result(96'h333333333333_444444444444);
        m_res_ready = 1'b1;
        wait_res_hs("mid_fresh_hs");
        check("mid_fresh_data", res_data, 96'h333333333333_444444444444);
        m_res_ready = 1'b0;

        // Randomized traffic through the divider model.
        do_reset();
        manual   = 1'b0;
        auto_div = 1'b1;
        p_req    = 60;
        p_full   = 30;
        p_ready  = 60;
        repeat (2000) step();
        p_req   = 0;
        p_full  = 0;
        p_ready = 100;
        n = 0;
        while ((req_valid || tx_exp.size() != 0 || res_exp.size() != 0 ||
                rx_fifo.size() != 0 || out_model != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) fail_timeout("random_drain");
        repeat (2) step();
        check("random_end_out", 96'(outstanding),    96'd0);
        check("random_end_err", 96'(err_unexpected), 96'd0);
        check("random_end_res", 96'(res_exp.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
